// File: rtl/q1_edge_window_counter.sv
// Counts edges of the registered q1 path over a programmable window and hands the count
// to a monitor via valid/ready. Define Q1_BOTH_EDGES_EN to count falling edges as well.
module q1_edge_window_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q1_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StCount, StReport} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state;
    logic             q1_d;
    logic             edge_hit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic [WIN_W-1:0] remaining;

`ifdef Q1_BOTH_EDGES_EN
    assign edge_hit = q1_in ^ q1_d;
`else
    assign edge_hit = q1_in & ~q1_d;
`endif

    // Saturating increment; an edge at full scale only flags overflow.
    always_comb begin
        cnt_next = cnt;
        ovf_next = ovf;
        if (edge_hit) begin
            if (cnt == CntMax) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            q1_d      <= 1'b0;
            cnt       <= '0;
            remaining <= '0;
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Tracks in every state so a window never starts on a stale edge.
            q1_d <= q1_in;
            case (state)
                StIdle: begin
                    if (start) begin
                        cnt  <= '0;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (win_len != '0) begin
                            remaining <= win_len;
                            state     <= StCount;
                        end else begin
                            cnt_out   <= '0;
                            cnt_valid <= 1'b1;
                            state     <= StReport;
                        end
                    end
                end
                StCount: begin
                    cnt       <= cnt_next;
                    ovf       <= ovf_next;
                    remaining <= remaining - WIN_W'(1);
                    if (remaining == WIN_W'(1)) begin
                        cnt_out   <= cnt_next;
                        cnt_valid <= 1'b1;
                        state     <= StReport;
                    end
                end
                StReport: begin
                    if (cnt_ready) begin
                        cnt_valid <= 1'b0;
                        ovf       <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    cnt_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q1_edge_window_counter.sv
// Bench for q1_edge_window_counter: an 8-bit and a 4-bit counter share one stimulus stream
// and are compared against an edge count computed from the driven q1 sample sequence.
module tb_q1_edge_window_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        q1_in = 1'b0;
    logic        start = 1'b0;
    logic        cnt_ready = 1'b0;
    logic [15:0] win_len = '0;

    logic [7:0]  cnt_a;
    logic        val_a, ovf_a, busy_a;
    logic [3:0]  cnt_b;
    logic        val_b, ovf_b, busy_b;
    logic [15:0] obs;

    int checks = 0;
    int failures = 0;
    logic seq [0:127];

    always #5 clk = ~clk;

    assign obs = {val_a, cnt_a, ovf_a, val_b, cnt_b, ovf_b};

    q1_edge_window_counter #(.CNT_W(8), .WIN_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .q1_in(q1_in), .start(start), .win_len(win_len),
        .cnt_out(cnt_a), .cnt_valid(val_a), .cnt_ready(cnt_ready), .ovf(ovf_a), .busy(busy_a)
    );

    q1_edge_window_counter #(.CNT_W(4), .WIN_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .q1_in(q1_in), .start(start), .win_len(win_len),
        .cnt_out(cnt_b), .cnt_valid(val_b), .cnt_ready(cnt_ready), .ovf(ovf_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // seq[0] is q1 at the accepting edge; seq[1..len] are the window samples.
    function automatic int model_edges(input int len);
        int n = 0;
        for (int i = 1; i <= len; i++) begin
`ifdef Q1_BOTH_EDGES_EN
            if (seq[i] != seq[i-1]) n++;
`else
            if (seq[i] && !seq[i-1]) n++;
`endif
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_pack(input int e, input bit v, input bit ovf_live);
        logic [7:0] ca;
        logic [3:0] cb;
        ca = (e > 255) ? 8'hff : 8'(e);
        cb = (e > 15) ? 4'hf : 4'(e);
        return {v, ca, ovf_live && (e > 255), v, cb, ovf_live && (e > 15)};
    endfunction

    task automatic fill_seq(input int mode);
        for (int i = 0; i < 128; i++) begin
            case (mode)
                0:       seq[i] = 1'b0;
                1:       seq[i] = i[0];
                2:       seq[i] = 1'($urandom);
                3:       seq[i] = 1'b1;
                default: seq[i] = ($urandom_range(0, 3) == 0);
            endcase
        end
    endtask

    // Drives one window and returns the number of edges, counting the start edge, until valid.
    task automatic drive_window(input int len, input bit ready, output int lat);
        start     = 1'b1;
        win_len   = 16'(len);
        q1_in     = seq[0];
        cnt_ready = ready;
        step();
        start = 1'b0;
        lat   = 1;
        while (val_a !== 1'b1 && lat < len + 8) begin
            q1_in = seq[lat];
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        q1_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_pack(0, 0, 0) || {busy_a, busy_b} !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold outputs=%h busy=%b required=%h busy=00",
                     obs, {busy_a, busy_b}, exp_pack(0, 0, 0));
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            q1_in = 1'($urandom);
            step();
            checks++;
            if (obs !== exp_pack(0, 0, 0) || {busy_a, busy_b} !== 2'b00) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d outputs=%h busy=%b required=%h busy=00",
                         k, obs, {busy_a, busy_b}, exp_pack(0, 0, 0));
            end
        end
    endtask

    task automatic test_basic();
        int lat, e;
        fill_seq(1);
        drive_window(10, 1'b1, lat);
        e = model_edges(10);
        checks++;
        if (lat !== 11) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=11", lat);
        end
        checks++;
        if (obs !== exp_pack(e, 1, 1) || {busy_a, busy_b} !== 2'b11) begin
            failures++;
            $display("FAIL basic_result got=%h busy=%b required=%h busy=11",
                     obs, {busy_a, busy_b}, exp_pack(e, 1, 1));
        end
        step();
        checks++;
        if (obs !== exp_pack(e, 0, 0) || {busy_a, busy_b} !== 2'b00) begin
            failures++;
            $display("FAIL basic_handshake got=%h busy=%b required=%h busy=00",
                     obs, {busy_a, busy_b}, exp_pack(e, 0, 0));
        end
    endtask

    task automatic test_boundary();
        int lat, e;
        fill_seq(0);
        seq[4] = 1'b1;
        drive_window(4, 1'b1, lat);
        e = model_edges(4);
        checks++;
        if (lat !== 5 || obs !== exp_pack(e, 1, 1)) begin
            failures++;
            $display("FAIL boundary_last_cycle lat=%0d got=%h required lat=5 %h",
                     lat, obs, exp_pack(e, 1, 1));
        end
        q1_in = 1'b0;
        step();
        step();
        fill_seq(0);
        drive_window(4, 1'b1, lat);
        q1_in = 1'b1;
        step();
        checks++;
        if (obs !== exp_pack(0, 0, 0) || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL boundary_after_window got=%h busy=%b required=%h busy=0",
                     obs, busy_a, exp_pack(0, 0, 0));
        end
        // q1 already high when the window opens: no edge until it falls and rises.
        fill_seq(3);
        drive_window(6, 1'b1, lat);
        e = model_edges(6);
        checks++;
        if (obs !== exp_pack(e, 1, 1)) begin
            failures++;
            $display("FAIL held_high_start got=%h required=%h", obs, exp_pack(e, 1, 1));
        end
        q1_in = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        int lat, e;
        fill_seq(1);
        drive_window(40, 1'b1, lat);
        e = model_edges(40);
        checks++;
        if (lat !== 41 || obs !== exp_pack(e, 1, 1)) begin
            failures++;
            $display("FAIL saturation lat=%0d got=%h required lat=41 %h",
                     lat, obs, exp_pack(e, 1, 1));
        end
        step();
        fill_seq(0);
        drive_window(12, 1'b1, lat);
        checks++;
        if (obs !== exp_pack(0, 1, 1)) begin
            failures++;
            $display("FAIL saturation_next_clean got=%h required=%h", obs, exp_pack(0, 1, 1));
        end
        step();
    endtask

    task automatic test_backpressure();
        int lat, e, len;
        len = $urandom_range(5, 20);
        fill_seq(2);
        drive_window(len, 1'b0, lat);
        e = model_edges(len);
        for (int k = 0; k < 5; k++) begin
            start   = (k == 2);
            win_len = 16'd3;
            q1_in   = 1'($urandom);
            step();
            checks++;
            if (obs !== exp_pack(e, 1, 1) || {busy_a, busy_b} !== 2'b11) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d got=%h busy=%b required=%h busy=11",
                         k, obs, {busy_a, busy_b}, exp_pack(e, 1, 1));
            end
        end
        start     = 1'b0;
        cnt_ready = 1'b1;
        step();
        checks++;
        if (obs !== exp_pack(e, 0, 0) || {busy_a, busy_b} !== 2'b00) begin
            failures++;
            $display("FAIL backpressure_release got=%h busy=%b required=%h busy=00",
                     obs, {busy_a, busy_b}, exp_pack(e, 0, 0));
        end
        step();
        checks++;
        if (busy_a !== 1'b0 || val_a !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored_in_report busy=%b valid=%b required busy=0 valid=0",
                     busy_a, val_a);
        end
    endtask

    task automatic test_zero_and_abort();
        int lat;
        int seen;
        fill_seq(2);
        drive_window(0, 1'b1, lat);
        checks++;
        if (lat !== 1 || obs !== exp_pack(0, 1, 1) || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL zero_window lat=%0d got=%h busy=%b required lat=1 %h busy=1",
                     lat, obs, busy_a, exp_pack(0, 1, 1));
        end
        step();
        fill_seq(1);
        start   = 1'b1;
        win_len = 16'd20;
        q1_in   = seq[0];
        step();
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            q1_in = seq[i];
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== exp_pack(0, 0, 0) || {busy_a, busy_b} !== 2'b00) begin
            failures++;
            $display("FAIL abort_immediate got=%h busy=%b required=%h busy=00",
                     obs, {busy_a, busy_b}, exp_pack(0, 0, 0));
        end
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            q1_in = 1'($urandom);
            step();
            if (val_a !== 1'b0 || val_b !== 1'b0 || busy_a !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_result active_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat, e;
        fill_seq(1);
        drive_window(3, 1'b1, lat);
        fill_seq(2);
        start   = 1'b1;
        win_len = 16'd2;
        q1_in   = seq[0];
        step();
        checks++;
        if (val_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap valid=%b busy=%b required valid=0 busy=0", val_a, busy_a);
        end
        step();
        start = 1'b0;
        checks++;
        if (val_a !== 1'b0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept valid=%b busy=%b required valid=0 busy=1", val_a, busy_a);
        end
        q1_in = seq[1];
        step();
        q1_in = seq[2];
        step();
        e = model_edges(2);
        checks++;
        if (obs !== exp_pack(e, 1, 1)) begin
            failures++;
            $display("FAIL b2b_result got=%h required=%h", obs, exp_pack(e, 1, 1));
        end
        step();
    endtask

    task automatic test_random();
        int lat, e, len, waits;
        bit rdy;
        for (int t = 0; t < 25; t++) begin
            len   = $urandom_range(0, 40);
            rdy   = 1'($urandom);
            waits = $urandom_range(0, 3);
            fill_seq($urandom_range(0, 4));
            drive_window(len, rdy, lat);
            e = model_edges(len);
            checks++;
            if (lat !== len + 1 || obs !== exp_pack(e, 1, 1)) begin
                failures++;
                $display("FAIL random_window t=%0d len=%0d lat=%0d got=%h required lat=%0d %h",
                         t, len, lat, obs, len + 1, exp_pack(e, 1, 1));
            end
            if (!rdy) begin
                repeat (waits) begin
                    q1_in = 1'($urandom);
                    step();
                end
                cnt_ready = 1'b1;
            end
            step();
            checks++;
            if (obs !== exp_pack(e, 0, 0) || busy_a !== 1'b0) begin
                failures++;
                $display("FAIL random_handshake t=%0d got=%h busy=%b required=%h busy=0",
                         t, obs, busy_a, exp_pack(e, 0, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_saturation();
        test_backpressure();
        test_zero_and_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
